rst_seq: RTL and testbench
==========================

Name: rst_seq

Overview:
- Sits directly downstream of the power-on reset generator and consumes its `rstn` output.
- Turns the single reset into an ordered release of N per-subsystem resets.
- Each stage is released, then its init-done acknowledge is awaited before the next stage is released.
- A missing acknowledge triggers a timeout: all stages go back into reset and the sequence retries a bounded number of times before latching a fault.

Parameters:
- N_STAGE, 4: number of sequenced reset outputs (2..8).
- SETTLE_CYC, 16: cycles of `rstn` high before stage 0 is released.
- GAP_CYC, 8: cycles from an accepted ack to release of the next stage.
- TIMEOUT_CYC, 1024: ack window per stage, in cycles after release.
- HOLD_CYC, 32: cycles all stages are held in reset after a timeout, before retrying.
- MAX_RETRY, 2: retries allowed before FAULT.

Ports:
- clock_in, in, 1: sole clock, rising edge.
- rstn, in, 1: reset; synchronous, active-low, sampled on posedge clock_in.
- stage_ack, in, N_STAGE: level init-done from each stage; bit k is only meaningful while stage k is awaited.
- stage_rstn, out, N_STAGE: per-stage active-low reset, registered.
- all_ready, out, 1: high once every stage has acknowledged.
- timeout_err, out, 1: sticky; set on the first timeout.
- fault, out, 1: retries exhausted.
- cur_stage, out, $clog2(N_STAGE): index of the stage currently awaited or last released.
- retry_cnt, out, $clog2(MAX_RETRY+1): number of timeouts taken so far.

Behaviour:
- **Reset:** any posedge with rstn=0 forces state=IDLE and every output to 0 (stage_rstn=0, all_ready=0, timeout_err=0, fault=0, cur_stage=0, retry_cnt=0). All counters clear.
  - This applies in every state, including mid-sequence, READY and FAULT.
  - The upstream generator drives rstn high, then low, then high; the early high phase therefore starts a sequence that the low phase aborts. This is required behaviour.
- **Counter:** one shared down/up counter, width $clog2(max(SETTLE_CYC, GAP_CYC, TIMEOUT_CYC, HOLD_CYC)+1). It is cleared on every state entry. No wrap: it saturates at terminal count.
- **States:** IDLE, SETTLE, RELEASE, WAIT_ACK, GAP, READY, HOLD, FAULT.
- **IDLE:** at the first edge E0 with rstn=1, go to SETTLE.
- **SETTLE:** at E0+SETTLE_CYC, set stage_rstn[cur_stage]=1 and go to WAIT_ACK. Call this release edge Er.
- **WAIT_ACK:** stage_ack[cur_stage] is sampled at edges Er+1..Er+TIMEOUT_CYC.
  - First sample at 1 (edge Ea): if this is the last stage, go to READY with all_ready=1 at edge Ea+1. Otherwise go to GAP.
  - An ack already high at release is accepted at Er+1.
- **GAP:** at Ea+GAP_CYC, cur_stage+1 is loaded and that stage's stage_rstn bit goes 1 on the same edge. Return to WAIT_ACK.
- **Timeout:** ack still 0 at edge Er+TIMEOUT_CYC. On the same edge:
  - If retry_cnt<MAX_RETRY: stage_rstn=0 (all bits), timeout_err=1, retry_cnt+1, cur_stage=0, go to HOLD.
  - Else: stage_rstn=0, timeout_err=1, fault=1, go to FAULT.
  - Ack=1 on the final window edge wins over timeout.
- **HOLD:** after HOLD_CYC cycles, go to SETTLE (full SETTLE_CYC again).
- **READY:** stage_rstn all 1, all_ready=1. Later ack drops are ignored. The state is left only via rstn=0.
- **FAULT:** all outputs held (stage_rstn=0, fault=1). The state is left only via rstn=0.
- **Acks of non-current stages:** ignored in every state.
- **Release monotonicity:** within a pass, stage_rstn bits only rise, in index order. Once released, a bit stays 1 until timeout, FAULT or reset.

Decomposition:
- **Shared package rst_pkg:**
  - state enum rst_seq_state_t.
  - A function computing the counter width from the four cycle parameters.
  - Default cycle constants, so the reset generator and this sequencer stay consistent.
- **Sub-module rst_seq_timer:** the loadable cycle counter with clear, enable and terminal-count flag, instantiated once. The FSM, stage index and outputs stay in rst_seq.

Test Plan:
1. **Nominal release.** Defaults; rstn 0→1 at edge 10; each ack raised 3 cycles after its stage_rstn bit rises.
   - stage_rstn[0]=1 at edge 26, [1] at 37, [2] at 48, [3] at 59.
   - all_ready=1 at edge 63.
   - timeout_err=0.
2. **Ack pre-asserted.** stage_ack=4'b1111 before rstn rises at edge 0.
   - Releases at edges 16, 25, 34, 43.
   - all_ready at edge 45.
3. **Single timeout then success.** Stage 1 ack withheld for the first pass only.
   - At edge Er1+1024: stage_rstn=0, timeout_err=1, retry_cnt=1.
   - Stage 0 re-released HOLD_CYC+SETTLE_CYC=48 cycles later.
   - all_ready eventually 1 with timeout_err still 1.
4. **Retry exhaustion.** Stage 2 never acks.
   - Three timeouts occur; after the third, fault=1, retry_cnt=2, stage_rstn=0.
   - Outputs stay stable for 5000 further cycles.
5. **Abort mid-sequence.** rstn driven 0 for 1 cycle while in GAP after stage 1.
   - Next edge: all outputs 0, state IDLE.
   - After rstn=1, the sequence restarts from stage 0 with SETTLE_CYC timing.
6. **Boundary ack.** Stage 0 ack raised exactly on edge Er+1024 → accepted, no timeout. Raised on Er+1025 → timeout taken.

Source files
------------

// File: rtl/rst_pkg.sv
// Shared types and default timing for the reset sequencer
// and the upstream power-on reset generator.
package rst_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    RELEASE,
    WAIT_ACK,
    GAP,
    READY,
    HOLD,
    FAULT
  } rst_seq_state_t;

  localparam int DEF_N_STAGE     = 4;
  localparam int DEF_SETTLE_CYC  = 16;
  localparam int DEF_GAP_CYC     = 8;
  localparam int DEF_TIMEOUT_CYC = 1024;
  localparam int DEF_HOLD_CYC    = 32;
  localparam int DEF_MAX_RETRY   = 2;

  function automatic int max2(
    input int a,
    input int b
  );
    return (a > b) ? a : b;
  endfunction

  function automatic int cnt_width(
    input int s,
    input int g,
    input int t,
    input int h
  );
    return $clog2(max2(max2(s, g), max2(t, h)) + 1);
  endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Shared phase counter: clears on state entry, counts up
// and parks at the limit so it never wraps.
module rst_seq_timer #(
  parameter int W = 11
) (
  input  logic         clock_in,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] cnt;

  assign tc = (cnt == limit);

  always_ff @(posedge clock_in) begin
    if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rst_seq.sv
// Ordered per-stage reset release with ack wait,
// timeout, bounded retry and latched fault.
module rst_seq
  import rst_pkg::*;
#(
  parameter int N_STAGE     = DEF_N_STAGE,
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int GAP_CYC     = DEF_GAP_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int HOLD_CYC    = DEF_HOLD_CYC,
  parameter int MAX_RETRY   = DEF_MAX_RETRY
) (
  input  logic                           clock_in,
  input  logic                           rstn,
  input  logic [N_STAGE-1:0]             stage_ack,
  output logic [N_STAGE-1:0]             stage_rstn,
  output logic                           all_ready,
  output logic                           timeout_err,
  output logic                           fault,
  output logic [$clog2(N_STAGE)-1:0]     cur_stage,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
);

  localparam int CW =
    cnt_width(SETTLE_CYC, GAP_CYC, TIMEOUT_CYC, HOLD_CYC);
  localparam int SW = $clog2(N_STAGE);
  localparam int RW = $clog2(MAX_RETRY + 1);

  localparam logic [SW-1:0] LAST = SW'(N_STAGE - 1);
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);

  // Limits are one short: the entry edge itself clears the count.
  localparam logic [CW-1:0] L_SETTLE  = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] L_GAP     = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] L_TIMEOUT = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] L_HOLD    = CW'(HOLD_CYC - 1);

  rst_seq_state_t state;

  logic [CW-1:0] limit;
  logic          tc;
  logic          en;
  logic          clr;
  logic          leave;
  logic          ack;
  logic [SW-1:0] nxt_stage;

  assign ack       = stage_ack[cur_stage];
  assign nxt_stage = cur_stage + 1'b1;
  assign en        = (state != READY) && (state != FAULT);
  assign clr       = !rstn || leave;

  always_comb begin
    limit = '0;
    leave = 1'b0;
    unique case (state)
      IDLE: begin
        leave = 1'b1;
      end
      SETTLE: begin
        limit = L_SETTLE;
        leave = tc;
      end
      WAIT_ACK: begin
        limit = L_TIMEOUT;
        leave = ack || tc;
      end
      GAP: begin
        limit = L_GAP;
        leave = tc;
      end
      HOLD: begin
        limit = L_HOLD;
        leave = tc;
      end
      default: begin
        leave = 1'b0;
      end
    endcase
  end

  rst_seq_timer #(
    .W(CW)
  ) u_timer (
    .clock_in(clock_in),
    .clr     (clr),
    .en      (en),
    .limit   (limit),
    .tc      (tc)
  );

  always_ff @(posedge clock_in) begin
    if (!rstn) begin
      state       <= IDLE;
      stage_rstn  <= '0;
      all_ready   <= 1'b0;
      timeout_err <= 1'b0;
      fault       <= 1'b0;
      cur_stage   <= '0;
      retry_cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          state <= SETTLE;
        end
        SETTLE: begin
          if (tc) begin
            stage_rstn[cur_stage] <= 1'b1;
            state <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          // An ack on the last window edge beats the timeout.
          if (ack) begin
            state <= (cur_stage == LAST) ? READY : GAP;
          end else if (tc) begin
            stage_rstn  <= '0;
            timeout_err <= 1'b1;
            if (retry_cnt < RMAX) begin
              retry_cnt <= retry_cnt + 1'b1;
              cur_stage <= '0;
              state     <= HOLD;
            end else begin
              fault <= 1'b1;
              state <= FAULT;
            end
          end
        end
        GAP: begin
          if (tc) begin
            cur_stage <= nxt_stage;
            stage_rstn[nxt_stage] <= 1'b1;
            state <= WAIT_ACK;
          end
        end
        READY: begin
          stage_rstn <= '1;
          all_ready  <= 1'b1;
        end
        HOLD: begin
          if (tc) begin
            state <= SETTLE;
          end
        end
        FAULT: begin
          stage_rstn <= '0;
          fault      <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  a_fault_held: assert property (
    @(posedge clock_in) disable iff (!rstn)
      fault |-> (stage_rstn == '0)
  );

  a_ready_all: assert property (
    @(posedge clock_in) disable iff (!rstn)
      all_ready |-> (&stage_rstn)
  );

endmodule

// File: tb/tb_rst_seq.sv
// Scoreboard bench for rst_seq: directed stimulus pushes
// hand-timed output events; a monitor pops on every change.
module tb_rst_seq;

  typedef struct {
    int         cyc;
    logic [8:0] out;
  } ev_t;

  // flag groups {all_ready, timeout_err, fault, retry_cnt}
  localparam logic [4:0] F0  = 5'b0_0_0_00;
  localparam logic [4:0] FR  = 5'b1_0_0_00;
  localparam logic [4:0] T1  = 5'b0_1_0_01;
  localparam logic [4:0] T1R = 5'b1_1_0_01;
  localparam logic [4:0] T2  = 5'b0_1_0_10;
  localparam logic [4:0] T2F = 5'b0_1_1_10;

  logic       clock_in = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] stage_ack = 4'b0000;
  logic [3:0] stage_rstn;
  logic       all_ready;
  logic       timeout_err;
  logic       fault;
  logic [1:0] cur_stage;
  logic [1:0] retry_cnt;

  logic [8:0] outv;
  logic [8:0] prev = 9'b0;
  ev_t        q[$];
  ev_t        me;
  string      tag = "reset";
  bit         mon_en = 1'b0;
  bit         first = 1'b1;
  int         cyc = 0;
  int         t0 = 0;
  int         checks = 0;
  int         errors = 0;

  rst_seq dut (
    .clock_in   (clock_in),
    .rstn       (rstn),
    .stage_ack  (stage_ack),
    .stage_rstn (stage_rstn),
    .all_ready  (all_ready),
    .timeout_err(timeout_err),
    .fault      (fault),
    .cur_stage  (cur_stage),
    .retry_cnt  (retry_cnt)
  );

  always #5 clock_in = ~clock_in;

  always @(posedge clock_in) cyc <= cyc + 1;

  assign outv = {stage_rstn, all_ready, timeout_err,
                 fault, retry_cnt};

  always @(negedge clock_in) begin
    if (mon_en && outv !== prev) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL %s unexpected: got out=%b at edge %0d, want no change",
                 tag, outv, cyc - t0);
      end else begin
        me = q.pop_front();
        if (me.cyc != cyc || me.out !== outv) begin
          errors++;
          $display("FAIL %s event: got out=%b at edge %0d, want out=%b at edge %0d",
                   tag, outv, cyc - t0, me.out, me.cyc - t0);
        end
      end
      prev = outv;
    end
  end

  task automatic push(input int c, input logic [8:0] o);
    ev_t e;
    e.cyc = c;
    e.out = o;
    q.push_back(e);
  endtask

  task automatic ev(input int rel, input logic [3:0] s,
                    input logic [4:0] f);
    push(t0 + rel, {s, f});
  endtask

  task automatic at(input int e);
    while (cyc + 1 < t0 + e) @(negedge clock_in);
  endtask

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s %s: got %0h, want %0h", tag, name, got, want);
    end
  endtask

  task automatic begin_test(input string name, input int low,
                            input logic [3:0] ack);
    @(negedge clock_in);
    tag = name;
    rstn = 1'b0;
    stage_ack = ack;
    if (first) first = 1'b0;
    else push(cyc + 1, 9'b0);
    repeat (low) @(negedge clock_in);
    rstn = 1'b1;
    t0 = cyc + 1;
  endtask

  task automatic end_test(input int rel);
    at(rel);
    @(negedge clock_in);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s pending: got %0d unseen events, want 0",
               tag, q.size());
      q.delete();
    end
  endtask

  initial begin
    repeat (3) @(negedge clock_in);
    chk("reset_out", 32'(outv), 32'd0);
    chk("reset_stage", 32'(cur_stage), 32'd0);
    prev = outv;
    mon_en = 1'b1;

    begin_test("nominal", 10, 4'b0000);
    ev(16, 4'b0001, F0);
    ev(27, 4'b0011, F0);
    ev(38, 4'b0111, F0);
    ev(49, 4'b1111, F0);
    ev(53, 4'b1111, FR);
    at(19); stage_ack = 4'b0001;
    at(30); stage_ack = 4'b0011;
    at(41); stage_ack = 4'b0111;
    at(52); stage_ack = 4'b1111;
    end_test(70);

    begin_test("preack", 5, 4'b1111);
    ev(16, 4'b0001, F0);
    ev(25, 4'b0011, F0);
    ev(34, 4'b0111, F0);
    ev(43, 4'b1111, F0);
    ev(45, 4'b1111, FR);
    end_test(60);

    begin_test("retry1", 5, 4'b1101);
    ev(16,   4'b0001, F0);
    ev(25,   4'b0011, F0);
    ev(1049, 4'b0000, T1);
    ev(1097, 4'b0001, T1);
    ev(1106, 4'b0011, T1);
    ev(1115, 4'b0111, T1);
    ev(1124, 4'b1111, T1);
    ev(1126, 4'b1111, T1R);
    at(1060); stage_ack = 4'b1111;
    end_test(1140);

    begin_test("exhaust", 5, 4'b1011);
    ev(16,   4'b0001, F0);
    ev(25,   4'b0011, F0);
    ev(34,   4'b0111, F0);
    ev(1058, 4'b0000, T1);
    ev(1106, 4'b0001, T1);
    ev(1115, 4'b0011, T1);
    ev(1124, 4'b0111, T1);
    ev(2148, 4'b0000, T2);
    ev(2196, 4'b0001, T2);
    ev(2205, 4'b0011, T2);
    ev(2214, 4'b0111, T2);
    ev(3238, 4'b0000, T2F);
    end_test(3238 + 5000);
    chk("fault_hold", 32'(outv), 32'({4'b0000, T2F}));

    begin_test("abort", 5, 4'b1111);
    ev(16, 4'b0001, F0);
    ev(25, 4'b0011, F0);
    ev(30, 4'b0000, F0);
    ev(47, 4'b0001, F0);
    ev(56, 4'b0011, F0);
    ev(65, 4'b0111, F0);
    ev(74, 4'b1111, F0);
    ev(76, 4'b1111, FR);
    at(30);
    chk("gap_stage", 32'(cur_stage), 32'd1);
    rstn = 1'b0;
    at(31);
    chk("abort_stage", 32'(cur_stage), 32'd0);
    rstn = 1'b1;
    end_test(95);

    begin_test("ack_last", 5, 4'b0000);
    ev(16,   4'b0001, F0);
    ev(1048, 4'b0011, F0);
    ev(1057, 4'b0111, F0);
    ev(1066, 4'b1111, F0);
    ev(1068, 4'b1111, FR);
    at(1040); stage_ack = 4'b0001;
    at(1041); stage_ack = 4'b1111;
    end_test(1080);

    begin_test("ack_late", 5, 4'b0000);
    ev(16,   4'b0001, F0);
    ev(1040, 4'b0000, T1);
    ev(1088, 4'b0001, T1);
    ev(1097, 4'b0011, T1);
    ev(1106, 4'b0111, T1);
    ev(1115, 4'b1111, T1);
    ev(1117, 4'b1111, T1R);
    at(1041); stage_ack = 4'b1111;
    end_test(1130);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
